// File: rtl/softmax_max_finder.sv
// Pipelined signed max-reduction over an N-element vector: a registered binary comparator
// tree alongside a matching delay line, so each vector leaves together with its maximum.
module softmax_max_finder #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 32,
  parameter int LEVELS    = $clog2(N)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic signed [BIT_WIDTH-1:0] i_data [N],
  output logic signed [BIT_WIDTH-1:0] o_data [N],
  output logic signed [BIT_WIDTH-1:0] o_maxValue,
  output logic                        o_valid
);

  if ((N < 2) || (N > 64) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("softmax_max_finder: N must be a power of two in 2..64");
  end
  if (LEVELS != $clog2(N)) begin : g_bad_levels
    $error("softmax_max_finder: LEVELS is derived from N and must not be overridden");
  end

  // All tree levels packed into one array; level k starts at 2N - 2N/2^k.
  localparam int NODES = 2 * N - 1;

  function automatic int lvl_off(input int k);
    return (2 * N) - ((2 * N) >> k);
  endfunction

  // Ties keep the lower-index operand.
  function automatic logic signed [BIT_WIDTH-1:0] smax(
    input logic signed [BIT_WIDTH-1:0] lo,
    input logic signed [BIT_WIDTH-1:0] hi
  );
    return (hi > lo) ? hi : lo;
  endfunction

  logic signed [BIT_WIDTH-1:0] node_d [NODES];
  logic signed [BIT_WIDTH-1:0] node_q [NODES];
  logic signed [BIT_WIDTH-1:0] dly_d  [LEVELS+1][N];
  logic signed [BIT_WIDTH-1:0] dly_q  [LEVELS+1][N];
  logic [LEVELS:0]             vld_d, vld_q;

  logic signed [BIT_WIDTH-1:0] out_data_d [N];
  logic signed [BIT_WIDTH-1:0] out_data_q [N];
  logic signed [BIT_WIDTH-1:0] out_max_d, out_max_q;
  logic                        out_vld_d, out_vld_q;

  always_comb begin
    node_d = node_q;
    dly_d  = dly_q;
    vld_d  = {vld_q[LEVELS-1:0], i_valid};

    // Stage 0: capture
    if (i_valid) begin
      for (int j = 0; j < N; j++) begin
        node_d[j] = i_data[j];
      end
      dly_d[0] = i_data;
    end

    // Levels 1..LEVELS: each stage loads only behind a valid vector
    for (int k = 1; k <= LEVELS; k++) begin
      if (vld_q[k-1]) begin
        dly_d[k] = dly_q[k-1];
        for (int j = 0; j < (N >> k); j++) begin
          node_d[lvl_off(k) + j] = smax(node_q[lvl_off(k-1) + 2*j],
                                        node_q[lvl_off(k-1) + 2*j + 1]);
        end
      end
    end

    // Output stage
    out_vld_d  = vld_q[LEVELS];
    out_max_d  = out_max_q;
    out_data_d = out_data_q;
    if (vld_q[LEVELS]) begin
      out_max_d  = node_q[NODES-1];
      out_data_d = dly_q[LEVELS];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int n = 0; n < NODES; n++) begin
        node_q[n] <= '0;
      end
      for (int k = 0; k <= LEVELS; k++) begin
        for (int j = 0; j < N; j++) begin
          dly_q[k][j] <= '0;
        end
      end
      for (int j = 0; j < N; j++) begin
        out_data_q[j] <= '0;
      end
      vld_q     <= '0;
      out_max_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      node_q     <= node_d;
      dly_q      <= dly_d;
      vld_q      <= vld_d;
      out_data_q <= out_data_d;
      out_max_q  <= out_max_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign o_data     = out_data_q;
  assign o_maxValue = out_max_q;
  assign o_valid    = out_vld_q;

endmodule

// File: doc/softmax_max_finder.md
# softmax_max_finder

Pipelined max-reduction stage of the 32-element softmax datapath, sitting directly upstream of the max-subtraction stage. It accepts one vector of N signed Q2.14 values per cycle and finds the maximum with a registered binary comparator tree. It outputs the maximum together with the original vector, delayed to line up with it, so the next stage can compute x[i] − max on the same cycle.

## Interface
Parameters:
- BIT_WIDTH, 16: element width, signed Q2.14.
- N, 32: elements per vector. Must be a power of two, 2..64; other values fail elaboration.
- LEVELS, $clog2(N): comparator-tree depth. This is derived and must not be overridden.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  i_data holds a vector this cycle.
- i_data  in  N × BIT_WIDTH signed  input vector, Q2.14.
- o_data  out  N × BIT_WIDTH signed  delayed copy of the input vector, Q2.14, unchanged.
- o_maxValue  out  BIT_WIDTH signed  maximum of that vector, Q2.14.
- o_valid  out  1  o_data and o_maxValue are valid; high for exactly one cycle per accepted vector.

## Operation
- Stage 0 (capture): on i_valid=1, register i_data into the level-0 node array and into the data delay line; set valid[0].
- Levels 1..LEVELS: level k holds N/2^k nodes.
  - node[k][j] = signed max(node[k-1][2j], node[k-1][2j+1]).
  - Each level is one register stage with its own valid bit: valid[k] <= valid[k-1].
- Comparison is signed two's complement and uses the full BIT_WIDTH. There is no widening, saturation or rounding; the max is bit-exact to one of the inputs.
- On a tie the lower-index operand is selected. The selected value is identical either way.
- Data delay line: LEVELS+1 stages of N×BIT_WIDTH registers, one per tree level, so the vector exits on the same cycle as its maximum.
- Output registers:
  - o_maxValue <= node[LEVELS][0]
  - o_data <= delayed vector
  - o_valid <= valid[LEVELS]
- Fully pipelined with no backpressure: a new vector is accepted every cycle that i_valid=1. The downstream stage must always accept.
- Bubbles: a stage's data registers load only when the valid bit entering that stage is 1; otherwise they hold. Therefore o_data and o_maxValue keep the last valid result while o_valid=0.
- Vectors never reorder, merge or drop, whatever the spacing between them (back-to-back, single-cycle gaps, long idle periods).

## Timing
- Reset:
  - Asserting i_rst immediately clears all valid bits, all tree nodes, the delay line, o_data, o_maxValue and o_valid to 0.
  - Reset mid-operation discards every vector in flight. No o_valid pulse appears for any of them.
  - On the first clock edge after i_rst deasserts, i_valid is sampled normally.
- Latency is L = LEVELS + 2 cycles (7 for N=32):
  - i_valid=1 sampled at edge t gives o_valid=1 in the cycle after edge t+L−1.
  - Stated differently, o_valid rises L edges after the capturing edge, counting the capturing edge as edge 1.
- Throughput: 1 vector per cycle. Back-to-back inputs give back-to-back o_valid pulses.
- o_valid is a single-cycle pulse per vector and is never held longer.
- There are no combinational paths from any input to any output.

## Test plan
- Reset: assert i_rst with i_valid=1, then release.
  - Every output must be 0 during reset.
  - No o_valid may appear before the first post-reset vector has travelled the full 7-cycle latency.
- Ramp: i_data[i] = i×512, one vector.
  - Exactly 7 cycles later: o_maxValue = 15872 (0x3E00), o_data equal to the input, o_valid high for one cycle.
- All negative with the max at the last index: all elements −32768, except i_data[31] = −1.
  - o_maxValue = −1 (0xFFFF). This checks the signed compare.
- Ties: all 32 elements = 0x1234.
  - o_maxValue = 0x1234 and o_data unchanged.
- Back-to-back and bubbles: vectors A (max 100 at index 0), B (max −5 at index 17) and C (max 8191 at index 9), with i_valid pattern 1,1,0,1.
  - o_valid pattern must be 1,1,0,1 with maxima 100, −5, 8191.
  - o_data/o_maxValue must hold B's result during the gap cycle.
- Reset mid-flight: assert i_rst 3 cycles after a vector is captured, deassert, then send a vector with max 42.
  - Only one o_valid appears, carrying 42, 7 cycles after its capture.
